rsbus_d2r_mw_extractor: RTL and testbench

//  Multi-window ring-bus request extractor: next generation of the single-port d2r extractor.

---
 rtl/rsbus_d2r_mw_extractor_if.sv | 35 +++
 rtl/rsbus_d2r_mw_extractor.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rsbus_d2r_mw_extractor.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsbus_d2r_mw_extractor_if.sv
// rsbus_d2r_mw_extractor_if
//   Groups the ring input, ring output, extracted-frame port and truncation
//   flag of the multi-window d2r extractor.
//   slave  : extractor side (takes ring input and TX space, drives ring/frame out)
//   master : environment side (drives ring input and TX space)
//   Signals: i_sof/i_ctrl/i_bus ring input; o_sof/o_ctrl/o_bus ring output;
//            frm_o_stb/sof/eof/bus extracted words; frm_o_rdy/frm_o_rdyE TX space
//            ([2w] short, [2w+1] long); err_trunc truncation pulse.
interface rsbus_d2r_mw_extractor_if #(
  parameter int NUM_WIN = 1
);
  logic                 i_sof;
  logic [11:0]          i_ctrl;
  logic [71:0]          i_bus;
  logic                 o_sof;
  logic [11:0]          o_ctrl;
  logic [71:0]          o_bus;
  logic [NUM_WIN-1:0]   frm_o_stb;
  logic                 frm_o_sof;
  logic                 frm_o_eof;
  logic [71:0]          frm_o_bus;
  logic [2*NUM_WIN-1:0] frm_o_rdy;
  logic [2*NUM_WIN-1:0] frm_o_rdyE;
  logic                 err_trunc;

  modport master (
    output i_sof, i_ctrl, i_bus, frm_o_rdy, frm_o_rdyE,
    input  o_sof, o_ctrl, o_bus, frm_o_stb, frm_o_sof, frm_o_eof, frm_o_bus, err_trunc
  );

  modport slave (
    input  i_sof, i_ctrl, i_bus, frm_o_rdy, frm_o_rdyE,
    output o_sof, o_ctrl, o_bus, frm_o_stb, frm_o_sof, frm_o_eof, frm_o_bus, err_trunc
  );
endinterface

// File: rtl/rsbus_d2r_mw_extractor.sv
// rsbus_d2r_mw_extractor
//   Multi-window ring-bus request extractor. Each request header on the ring is
//   compared against NUM_WIN address windows (lowest index wins). Hit frames with
//   TX space are copied to the selected TX port and marked consumed on the ring;
//   hits without space are marked for retry (reco); everything else passes
//   bit-exact. Frames are word-counted to flag end-of-frame and truncation.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : rsbus_d2r_mw_extractor_if.slave (ring in/out, frame port, err_trunc)
//     stat_ext   : frames extracted per port, 16-bit saturating   (stats build only)
//     stat_reco  : frames marked retry, 16-bit saturating         (stats build only)
//   Optional feature macro: RSBUS_D2R_MW_STATS_EN adds the statistics counters.
//   Latency: frame port = input +1 (+2 with ADDR_REG), ring = input +2 (+3).
module rsbus_d2r_mw_extractor #(
  parameter int                     NUM_WIN     = 1,
  parameter logic [NUM_WIN*39-1:0]  WIN_BASE    = '0,
  parameter logic [NUM_WIN*39-1:0]  WIN_LAST    = '0,
  parameter int                     ADDR_REG    = 0,
  parameter int                     SHORT_WORDS = 2,
  parameter int                     LONG_WORDS  = 9
) (
  input logic                      clk,
  input logic                      rst_n,
  rsbus_d2r_mw_extractor_if.slave  bus
`ifdef RSBUS_D2R_MW_STATS_EN
  ,
  output logic [16*NUM_WIN-1:0]    stat_ext,
  output logic [15:0]              stat_reco
`endif
);

  localparam int         WW        = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam logic [3:0] SHORT_LEN = 4'(SHORT_WORDS);
  localparam logic [3:0] LONG_LEN  = 4'(LONG_WORDS);

  typedef enum logic {S_IDLE = 1'b0, S_EXT = 1'b1} state_t;

  // Window compare on the raw input; 40-bit so the top address cannot wrap.
  logic [38:0]        in_addr;
  logic [NUM_WIN-1:0] in_hit;
  assign in_addr = {bus.i_bus[38:3], 3'b000};

  generate
    for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
      assign in_hit[gi] = ({1'b0, in_addr} >= {1'b0, WIN_BASE[gi*39 +: 39]}) &&
                          ({1'b0, in_addr} <= {1'b0, WIN_LAST[gi*39 +: 39]});
    end
  endgenerate

  // Decision-stage word: raw input, or one register later when ADDR_REG is set.
  logic               d_sof;
  logic [11:0]        d_ctrl;
  logic [71:0]        d_bus;
  logic [NUM_WIN-1:0] d_hit;

  generate
    if (ADDR_REG != 0) begin : g_areg
      logic               a_sof_reg;
      logic               a_ctrl_hi_reg;
      logic [3:0]         a_bus_hi_reg;
      logic [NUM_WIN-1:0] a_hit_reg;
      logic [10:0]        a_ctrl_lo_reg;
      logic [67:0]        a_bus_lo_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_sof_reg     <= 1'b0;
          a_ctrl_hi_reg <= 1'b0;
          a_bus_hi_reg  <= '0;
          a_hit_reg     <= '0;
        end else begin
          a_sof_reg     <= bus.i_sof;
          a_ctrl_hi_reg <= bus.i_ctrl[11];
          a_bus_hi_reg  <= bus.i_bus[71:68];
          a_hit_reg     <= in_hit;
        end
      end

      always_ff @(posedge clk) begin
        a_ctrl_lo_reg <= bus.i_ctrl[10:0];
        a_bus_lo_reg  <= bus.i_bus[67:0];
      end

      assign d_sof  = a_sof_reg;
      assign d_ctrl = {a_ctrl_hi_reg, a_ctrl_lo_reg};
      assign d_bus  = {a_bus_hi_reg, a_bus_lo_reg};
      assign d_hit  = a_hit_reg;
    end else begin : g_noreg
      assign d_sof  = bus.i_sof;
      assign d_ctrl = bus.i_ctrl;
      assign d_bus  = bus.i_bus;
      assign d_hit  = in_hit;
    end
  endgenerate

  // Header decision
  logic          hdr_req, hit_any, rdy_sel, rdye_sel, ena, ena_e, reco;
  logic [WW-1:0] w_sel;

  always_comb begin
    hdr_req = d_sof & d_bus[71] & ~d_bus[2];
    hit_any = |d_hit;
    w_sel   = '0;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      if (d_hit[w]) w_sel = WW'(w);
    end
    rdy_sel  = 1'b0;
    rdye_sel = 1'b0;
    for (int w = 0; w < NUM_WIN; w++) begin
      if (w_sel == WW'(w)) begin
        rdy_sel  = bus.frm_o_rdy[2*w + (d_bus[39] ? 1 : 0)];
        rdye_sel = bus.frm_o_rdyE[2*w + (d_bus[39] ? 1 : 0)];
      end
    end
    ena   = hdr_req & hit_any & rdy_sel;
    ena_e = hdr_req & hit_any & (d_bus[69:68] == 2'b11) & rdye_sel;
    reco  = hdr_req & hit_any & ~ena & ~ena_e;
  end

  // Extraction FSM: S_EXT while the word count is below the frame length.
  state_t             state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [3:0]         tgt_reg, tgt_next;
  logic [WW-1:0]      port_reg, port_next;
  logic [NUM_WIN-1:0] stb_reg, stb_next;
  logic               fsof_reg, fsof_next;
  logic               feof_reg, feof_next;
  logic               trunc_reg, trunc_next;
  logic               ext;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tgt_next   = tgt_reg;
    port_next  = port_reg;
    fsof_next  = 1'b0;
    feof_next  = 1'b0;
    trunc_next = 1'b0;
    ext        = 1'b0;
    if (d_sof) begin
      // Any sof ends the current frame; a frame still short of its length is truncated.
      trunc_next = (state_reg == S_EXT);
      state_next = S_IDLE;
      if (ena | ena_e) begin
        ext        = 1'b1;
        port_next  = w_sel;
        tgt_next   = d_bus[39] ? LONG_LEN : SHORT_LEN;
        cnt_next   = 4'd1;
        fsof_next  = 1'b1;
        feof_next  = (tgt_next == 4'd1);
        state_next = feof_next ? S_IDLE : S_EXT;
      end
    end else if (state_reg == S_EXT) begin
      ext       = 1'b1;
      cnt_next  = cnt_reg + 4'd1;
      feof_next = (cnt_next == tgt_reg);
      if (feof_next) state_next = S_IDLE;
    end
    for (int w = 0; w < NUM_WIN; w++) begin
      stb_next[w] = ext && (port_next == WW'(w));
    end
  end

  // Stage 1: decision-stage word plus the ring edits to apply at stage 2.
  logic        s1_sof_reg, s1_ctrl_hi_reg, s1_clr_reg, s1_ctl0_reg, s1_reco_reg;
  logic [3:0]  s1_bus_hi_reg;
  logic [10:0] s1_ctrl_lo_reg;
  logic [67:0] s1_bus_lo_reg;
  logic [71:0] s1_bus;

  // Stage 2: ring output
  logic        o_sof_reg, o_ctrl_hi_reg;
  logic [3:0]  o_bus_hi_reg;
  logic [10:0] o_ctrl_lo_reg;
  logic [67:0] o_bus_lo_reg;

  assign s1_bus = {s1_bus_hi_reg, s1_bus_lo_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      tgt_reg        <= '0;
      port_reg       <= '0;
      stb_reg        <= '0;
      fsof_reg       <= 1'b0;
      feof_reg       <= 1'b0;
      trunc_reg      <= 1'b0;
      s1_sof_reg     <= 1'b0;
      s1_ctrl_hi_reg <= 1'b0;
      s1_bus_hi_reg  <= '0;
      s1_clr_reg     <= 1'b0;
      s1_ctl0_reg    <= 1'b0;
      s1_reco_reg    <= 1'b0;
      o_sof_reg      <= 1'b0;
      o_ctrl_hi_reg  <= 1'b0;
      o_bus_hi_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      tgt_reg        <= tgt_next;
      port_reg       <= port_next;
      stb_reg        <= stb_next;
      fsof_reg       <= fsof_next;
      feof_reg       <= feof_next;
      trunc_reg      <= trunc_next;
      s1_sof_reg     <= d_sof;
      s1_ctrl_hi_reg <= d_ctrl[11];
      s1_bus_hi_reg  <= d_bus[71:68];
      s1_clr_reg     <= ext;
      s1_ctl0_reg    <= d_sof & ena;   // express-only extraction keeps the header ctrl
      s1_reco_reg    <= reco;
      o_sof_reg      <= s1_sof_reg;
      o_ctrl_hi_reg  <= s1_ctl0_reg ? 1'b0 : s1_ctrl_hi_reg;
      o_bus_hi_reg   <= {s1_bus_hi_reg[3] & ~s1_clr_reg,
                         (s1_bus_hi_reg[2] & ~s1_clr_reg) | s1_reco_reg,
                         s1_bus_hi_reg[1:0]};
    end
  end

  always_ff @(posedge clk) begin
    s1_ctrl_lo_reg <= d_ctrl[10:0];
    s1_bus_lo_reg  <= d_bus[67:0];
    o_ctrl_lo_reg  <= s1_ctl0_reg ? 11'd0 : s1_ctrl_lo_reg;
    o_bus_lo_reg   <= s1_bus_lo_reg;
  end

  assign bus.o_sof     = o_sof_reg;
  assign bus.o_ctrl    = {o_ctrl_hi_reg, o_ctrl_lo_reg};
  assign bus.o_bus     = {o_bus_hi_reg, o_bus_lo_reg};
  assign bus.frm_o_stb = stb_reg;
  assign bus.frm_o_sof = fsof_reg;
  assign bus.frm_o_eof = feof_reg;
  assign bus.frm_o_bus = s1_bus;     // extracted copy is the unmodified word
  assign bus.err_trunc = trunc_reg;

`ifdef RSBUS_D2R_MW_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_stat
      logic [15:0] ext_cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ext_cnt_reg <= '0;
        end else if (fsof_next && stb_next[gi] && ext_cnt_reg != 16'hFFFF) begin
          ext_cnt_reg <= ext_cnt_reg + 16'd1;
        end
      end
      assign stat_ext[gi*16 +: 16] = ext_cnt_reg;
    end
  endgenerate

  logic [15:0] reco_cnt_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reco_cnt_reg <= '0;
    end else if (reco && reco_cnt_reg != 16'hFFFF) begin
      reco_cnt_reg <= reco_cnt_reg + 16'd1;
    end
  end
  assign stat_reco = reco_cnt_reg;
`endif

endmodule

// File: tb/tb_rsbus_d2r_mw_extractor.sv
// tb_rsbus_d2r_mw_extractor
//   Randomized scoreboard bench for rsbus_d2r_mw_extractor with two windows:
//   win0 0x0000-0x0FFF, win1 0x0800-0x1FFF (overlap 0x0800-0x0FFF -> port 0).
//   The driver runs a frame-level reference model and queues expected ring words,
//   extracted words and truncation pulses; a monitor compares DUT outputs.
module tb_rsbus_d2r_mw_extractor;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rsbus_d2r_mw_extractor_if #(.NUM_WIN(NW)) bif ();

`ifdef RSBUS_D2R_MW_STATS_EN
  logic [16*NW-1:0] stat_ext;
  logic [15:0]      stat_reco;
`endif

  rsbus_d2r_mw_extractor #(
    .NUM_WIN    (NW),
    .WIN_BASE   ({39'h800, 39'h0}),
    .WIN_LAST   ({39'h1FFF, 39'hFFF}),
    .ADDR_REG   (0),
    .SHORT_WORDS(2),
    .LONG_WORDS (9)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
`ifdef RSBUS_D2R_MW_STATS_EN
    ,
    .stat_ext (stat_ext),
    .stat_reco(stat_reco)
`endif
  );

  typedef struct {
    int          cyc;
    logic        sof;
    logic [11:0] ctrl;
    logic [71:0] bus;
  } ring_t;

  typedef struct {
    int          cyc;
    logic [1:0]  stb;
    logic        sof;
    logic        eof;
    logic [71:0] bus;
  } frm_t;

  ring_t rq[$];
  frm_t  fq[$];
  int    tq[$];

  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  bit in_reset = 1'b1;

  // reference-model state
  logic [38:0] win_base [NW] = '{39'h0, 39'h800};
  logic [38:0] win_last [NW] = '{39'hFFF, 39'h1FFF};
  int rem = 0;
  int cur_port = 0;
  int m_ext [NW] = '{0, 0};
  int m_reco = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int find_win(input logic [38:0] a);
    for (int w = 0; w < NW; w++) begin
      if (a >= win_base[w] && a <= win_last[w]) return w;
    end
    return -1;
  endfunction

  function automatic logic [71:0] rnd72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  function automatic logic [71:0] mk_hdr(input logic stb, input logic rc, input logic [1:0] pp,
                                         input logic len, input logic [38:0] addr, input logic req);
    logic [71:0] b;
    b = rnd72();
    b[71] = stb;
    b[70] = rc;
    b[69:68] = pp;
    b[39] = len;
    b[38:3] = addr[38:3];
    b[2] = ~req;
    return b;
  endfunction

  // Drive one ring word and record what the spec says must come out of it.
  task automatic send(input logic sof, input logic [11:0] ctrl, input logic [71:0] b,
                      input logic [3:0] rdy, input logic [3:0] rdye);
    ring_t r;
    frm_t  f;
    int    w, words, idx;
    logic  ok, oke;
    @(posedge clk);
    #1;
    bif.i_sof = sof;
    bif.i_ctrl = ctrl;
    bif.i_bus = b;
    bif.frm_o_rdy = rdy;
    bif.frm_o_rdyE = rdye;
    r.cyc = cyc + 2;
    r.sof = sof;
    r.ctrl = ctrl;
    r.bus = b;
    f.cyc = cyc + 1;
    f.bus = b;
    f.sof = 1'b0;
    f.eof = 1'b0;
    f.stb = '0;
    if (sof) begin
      if (rem > 0) tq.push_back(cyc + 1);
      rem = 0;
      if (b[71] && !b[2]) begin
        w = find_win({b[38:3], 3'b000});
        if (w >= 0) begin
          words = b[39] ? 9 : 2;
          idx = 2 * w + (b[39] ? 1 : 0);
          ok = rdy[idx];
          oke = (b[69:68] == 2'b11) && rdye[idx];
          if (ok || oke) begin
            r.bus[71] = 1'b0;
            r.bus[70] = 1'b0;
            if (ok) r.ctrl = '0;
            f.stb = 2'(1 << w);
            f.sof = 1'b1;
            f.eof = (words == 1);
            fq.push_back(f);
            rem = words - 1;
            cur_port = w;
            m_ext[w]++;
          end else begin
            r.bus[70] = 1'b1;
            m_reco++;
          end
        end
      end
    end else if (rem > 0) begin
      r.bus[71] = 1'b0;
      r.bus[70] = 1'b0;
      f.stb = 2'(1 << cur_port);
      f.eof = (rem == 1);
      fq.push_back(f);
      rem--;
    end
    rq.push_back(r);
  endtask

  task automatic data_word();
    send(1'b0, 12'($urandom()), rnd72(), 4'($urandom()), 4'($urandom()));
  endtask

  // Header followed by nw-1 data words; TX space varies after the header.
  task automatic frame(input logic [71:0] h, input int nw, input logic [3:0] rdy, input logic [3:0] rdye);
    $display("frame: addr=%h len=%0d pp=%0d stb=%0d req=%0d words=%0d rdy=%b rdyE=%b",
             {h[38:3], 3'b000}, h[39], h[69:68], h[71], !h[2], nw, rdy, rdye);
    send(1'b1, 12'($urandom()), h, rdy, rdye);
    for (int i = 1; i < nw; i++) data_word();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_stb"}, 128'(bif.frm_o_stb), 128'(0));
    chk({nm, "_fsof"}, 128'(bif.frm_o_sof), 128'(0));
    chk({nm, "_eof"}, 128'(bif.frm_o_eof), 128'(0));
    chk({nm, "_trunc"}, 128'(bif.err_trunc), 128'(0));
    chk({nm, "_osof"}, 128'(bif.o_sof), 128'(0));
    chk({nm, "_octl11"}, 128'(bif.o_ctrl[11]), 128'(0));
    chk({nm, "_obushi"}, 128'(bif.o_bus[71:68]), 128'(0));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    in_reset = 1'b1;
    rst_n = 1'b0;
    bif.i_sof = 1'b0;
    bif.i_ctrl = '0;
    bif.i_bus = '0;
    rq.delete();
    fq.delete();
    tq.delete();
    rem = 0;
    m_ext = '{0, 0};
    m_reco = 0;
    @(negedge clk);
    check_reset_outputs("reset");
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    ring_t r;
    frm_t  f;
    logic  e;
    if (rst_n && !in_reset) begin
      if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        r = rq.pop_front();
        chk("ring_word", 128'({bif.o_sof, bif.o_ctrl, bif.o_bus}), 128'({r.sof, r.ctrl, r.bus}));
      end
      if (bif.frm_o_stb != '0) begin
        if (fq.size() == 0) begin
          chk("frm_unexpected", 128'(bif.frm_o_stb), 128'(0));
        end else begin
          f = fq.pop_front();
          chk("frm_cycle", 128'(cyc), 128'(f.cyc));
          chk("frm_word", 128'({bif.frm_o_stb, bif.frm_o_sof, bif.frm_o_eof, bif.frm_o_bus}),
              128'({f.stb, f.sof, f.eof, f.bus}));
        end
      end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
        f = fq.pop_front();
        chk("frm_missing", 128'(bif.frm_o_stb), 128'(f.stb));
      end
      e = (tq.size() > 0 && tq[0] <= cyc);
      if (bif.err_trunc || e) begin
        if (e) void'(tq.pop_front());
        chk("err_trunc", 128'(bif.err_trunc), 128'(e));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [38:0] addr_tab [10];
    logic [38:0] a;
    logic [71:0] h;
    int nw, full;
    addr_tab = '{39'h10, 39'h7F8, 39'h800, 39'hFF8, 39'h1000, 39'h1008,
                 39'h1FF8, 39'h2000, 39'h7F_FFFF_FFF8, 39'h0};
    bif.i_sof = 1'b0;
    bif.i_ctrl = '0;
    bif.i_bus = '0;
    bif.frm_o_rdy = '0;
    bif.frm_o_rdyE = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_reset = 1'b0;

    // short hit in win1 with short space on port 1
    frame(mk_hdr(1, 0, 2'b01, 0, 39'h1008, 1), 2, 4'b0100, 4'b0000);
    // same header without space -> retry mark
    frame(mk_hdr(1, 0, 2'b01, 0, 39'h1008, 1), 2, 4'b0000, 4'b0000);
    // express long frame into port 0, ctrl kept
    frame(mk_hdr(1, 0, 2'b11, 1, 39'h10, 1), 9, 4'b0000, 4'b0010);
    // long frame cut by a new sof at word 5; new header hits the overlap -> port 0
    frame(mk_hdr(1, 0, 2'b00, 1, 39'h10, 1), 4, 4'b1111, 4'b0000);
    frame(mk_hdr(1, 0, 2'b00, 0, 39'h800, 1), 2, 4'b1111, 4'b0000);
    // miss past the last window
    frame(mk_hdr(1, 0, 2'b00, 0, 39'h2000, 1), 2, 4'b1111, 4'b1111);
    // reset during word 3 of an extracted long frame, then the rest of its words
    frame(mk_hdr(1, 0, 2'b00, 1, 39'h1800, 1), 2, 4'b1000, 4'b0000);
    do_reset(2);
    for (int i = 0; i < 7; i++) data_word();

    for (int i = 0; i < 300; i++) begin
      a = addr_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) a = a + 39'({$urandom_range(0, 255), 3'b000});
      if ($urandom_range(0, 9) == 0) a = 39'({$urandom(), $urandom()});
      h = mk_hdr($urandom_range(0, 7) != 0, 1'($urandom()), 2'($urandom()), 1'($urandom()),
                 a, $urandom_range(0, 7) != 0);
      full = h[39] ? 9 : 2;
      nw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, full) : full;
      frame(h, nw, 4'($urandom()), 4'($urandom()));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) data_word();
    end

    for (int i = 0; i < 12; i++) begin
      send(1'b0, '0, '0, '0, '0);
    end
    repeat (4) @(negedge clk);
    chk("ring_queue_left", 128'(rq.size()), 128'(0));
    chk("frm_queue_left", 128'(fq.size()), 128'(0));
    chk("trunc_queue_left", 128'(tq.size()), 128'(0));
`ifdef RSBUS_D2R_MW_STATS_EN
    for (int w = 0; w < NW; w++) chk("stat_ext", 128'(stat_ext[w*16 +: 16]), 128'(m_ext[w]));
    chk("stat_reco", 128'(stat_reco), 128'(m_reco));
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
